// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single-port data memory between the pipeline memory stage (core)
// and a secondary bus master (DMA / program loader).
//
// The core owns the port by default and gets zero-latency access. The DMA is
// handed the port in bounded bursts. A handoff to the DMA happens either when
// the core is idle, or when the core has held the port against a waiting DMA
// for STARVE_LIMIT consecutive cycles. While the DMA owns the port, the
// pipeline is frozen through core_stall.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   core_req/we       memory-stage access and store enable
//   core_addr/wdata   memory-stage address and store data
//   core_rdata        load data (combinational from mem_rd)
//   core_stall        core access not serviced this cycle
//   dma_req/we/last   DMA request, write enable, final beat of burst
//   dma_addr/wdata    DMA address and write data
//   dma_gnt           DMA access accepted this cycle
//   dma_rdata/rvalid  registered DMA read data and its one-cycle valid pulse
//   mem_a/wd/we       memory address, write data, write enable
//   mem_rd            memory combinational read data
//   owner             0 = core owns the port, 1 = DMA owns the port
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              owner
);

    typedef enum logic [0:0] {
        S_CORE = 1'b0,
        S_DMA  = 1'b1
    } state_t;

    // Counters are 8 bits wide: both limits are legal only up to 255.
    localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);
    localparam logic [7:0] BURST_LAST_C   = 8'(MAX_BURST - 1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [7:0]          starve_cnt_r;
    logic [7:0]          starve_nxt_s;
    logic [7:0]          burst_cnt_r;
    logic [7:0]          burst_nxt_s;
    logic [DATA_W-1:0]   dma_rdata_r;
    logic                dma_rvalid_r;

    logic                mem_we_s;
    logic                dma_gnt_s;
    logic                core_stall_s;
    logic                dma_rd_hit_s;

    // Next-state, counter update and port mux for the two ownership states.
    always_comb begin
        state_nxt_s  = state_r;
        starve_nxt_s = starve_cnt_r;
        burst_nxt_s  = burst_cnt_r;
        mem_a        = core_addr;
        mem_wd       = core_wdata;
        mem_we_s     = 1'b0;
        dma_gnt_s    = 1'b0;
        core_stall_s = 1'b0;

        case (state_r)
            S_CORE: begin
                mem_we_s = core_req & core_we;

                // Count only contended cycles; an absent DMA request resets
                // the starvation history.
                if (!dma_req) begin
                    starve_nxt_s = 8'd0;
                end else if (core_req && (starve_cnt_r != STARVE_LIMIT_C)) begin
                    starve_nxt_s = starve_cnt_r + 8'd1;
                end else begin
                    starve_nxt_s = starve_cnt_r;
                end

                // The core access of this cycle is still serviced; the DMA
                // takes over from the next cycle on.
                if (dma_req && (!core_req || (starve_cnt_r == STARVE_LIMIT_C))) begin
                    state_nxt_s = S_DMA;
                end else begin
                    state_nxt_s = S_CORE;
                end
            end

            S_DMA: begin
                mem_a        = dma_addr;
                mem_wd       = dma_wdata;
                mem_we_s     = dma_req & dma_we;
                dma_gnt_s    = dma_req;
                core_stall_s = core_req;

                if (dma_req) begin
                    burst_nxt_s = burst_cnt_r + 8'd1;
                end else begin
                    burst_nxt_s = burst_cnt_r;
                end

                // With dma_req high the grant is implied, so dma_last and the
                // forced-release count only matter on granted cycles. Both
                // firing together collapse into the same single return.
                if (!dma_req || dma_last || (burst_cnt_r == BURST_LAST_C)) begin
                    state_nxt_s  = S_CORE;
                    burst_nxt_s  = 8'd0;
                    starve_nxt_s = 8'd0;
                end else begin
                    state_nxt_s  = S_DMA;
                end
            end

            default: begin
                state_nxt_s  = S_CORE;
                starve_nxt_s = 8'd0;
                burst_nxt_s  = 8'd0;
            end
        endcase
    end

    // Ownership state and arbitration counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_CORE;
            starve_cnt_r <= 8'd0;
            burst_cnt_r  <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            burst_cnt_r  <= burst_nxt_s;
        end
    end

    assign dma_rd_hit_s = dma_gnt_s & ~dma_we;

    // DMA read-return register; data holds between reads, valid is a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_rdata_r  <= {DATA_W{1'b0}};
            dma_rvalid_r <= 1'b0;
        end else if (dma_rd_hit_s) begin
            dma_rdata_r  <= mem_rd;
            dma_rvalid_r <= 1'b1;
        end else begin
            dma_rdata_r  <= dma_rdata_r;
            dma_rvalid_r <= 1'b0;
        end
    end

    // Strobes are gated with reset so nothing reaches the memory or the
    // requesters while reset is held, independent of the inputs.
    assign mem_we     = rst & mem_we_s;
    assign dma_gnt    = rst & dma_gnt_s;
    assign core_stall = rst & core_stall_s;

    assign core_rdata = mem_rd;
    assign dma_rdata  = dma_rdata_r;
    assign dma_rvalid = dma_rvalid_r;
    assign owner      = (state_r == S_DMA);

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the pipeline's memory stage (core) and a secondary bus master (DMA/program loader).
- Sits between the memory-stage control/address signals and the data memory instance.
- Core has default ownership and zero-latency access. The DMA gets the port in bounded bursts.
- A starvation counter forces a handoff when the core monopolises the port; a stall output freezes the pipeline while the DMA owns the port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, contended core cycles before a forced DMA handoff (legal range 1..255).
- MAX_BURST, 8, maximum DMA grants per ownership period (legal range 1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- core_req  in  1  memory-stage access this cycle (load or store).
- core_we  in  1  core store enable.
- core_addr  in  ADDR_W  core address (ALU result).
- core_wdata  in  DATA_W  core store data.
- core_rdata  out  DATA_W  core load data, combinational from mem_rd.
- core_stall  out  1  freeze pipeline; core access not serviced this cycle.
- dma_req  in  1  DMA access request.
- dma_we  in  1  DMA write enable.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_last  in  1  final beat of the current DMA burst.
- dma_gnt  out  1  DMA access accepted this cycle.
- dma_rdata  out  DATA_W  registered DMA read data.
- dma_rvalid  out  1  dma_rdata valid; one-cycle pulse.
- mem_a  out  ADDR_W  memory address.
- mem_wd  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable; memory writes on posedge.
- mem_rd  in  DATA_W  memory combinational read data.
- owner  out  1  0 = core owns the port, 1 = DMA owns the port (registered state bit).

Behaviour:

Reset and state:
- Two-state FSM: S_CORE (owner=0) and S_DMA (owner=1).
- Async reset (rst=0) forces:
  - state=S_CORE
  - starve_cnt=0, burst_cnt=0
  - dma_rvalid=0, dma_rdata=0
- Combinational outputs during reset: core_stall=0, dma_gnt=0, mem_we=0.

S_CORE:
- Mux selects core: mem_a=core_addr, mem_wd=core_wdata, mem_we=core_req&core_we.
- core_stall=0, dma_gnt=0.
- starve_cnt increments, saturating at STARVE_LIMIT, on each cycle with core_req&dma_req.
- starve_cnt clears when dma_req=0.
- Transition to S_DMA next cycle if dma_req & (!core_req | starve_cnt==STARVE_LIMIT). The current cycle's core access is still serviced.

S_DMA:
- Mux selects DMA: mem_a=dma_addr, mem_wd=dma_wdata, mem_we=dma_req&dma_we.
- dma_gnt=dma_req.
- core_stall=core_req.
- burst_cnt increments on each dma_gnt.
- Return to S_CORE next cycle if any of the following hold:
  - dma_req=0 (no grant that cycle)
  - dma_gnt & dma_last
  - dma_gnt & burst_cnt==MAX_BURST-1 (forced release)
- On exit, burst_cnt=0 and starve_cnt=0.
- Simultaneous dma_last and forced release produce a single return, with identical behaviour.

Read data paths:
- Granted DMA read (dma_gnt & !dma_we): dma_rdata<=mem_rd and dma_rvalid<=1 at the next posedge; otherwise dma_rvalid<=0.
- dma_rdata holds its value between reads.
- core_rdata=mem_rd at all times. It is valid only when core_req & !core_stall.

Handover and ownership rules:
- Handover always costs exactly one registered transition.
- There is no cycle in which both requesters are serviced.
- mem_we is never asserted for an un-granted requester.

Reset mid-burst:
- Immediate return to S_CORE.
- Pending dma_rvalid is dropped.
- The DMA must re-request.

Test Plan:
1. Core only: core_req=1, core_we=1, addr=0x10, wdata=0xDEADBEEF; then a read of 0x10 → mem_we=1 on the write cycle; core_rdata=0xDEADBEEF; core_stall=0 throughout; owner=0.
2. Idle core, DMA 3-beat write burst to 0x20..0x28 with dma_last on beat 3:
   - owner=1 the cycle after dma_req.
   - dma_gnt on 3 consecutive cycles.
   - owner=0 the following cycle.
   - Memory holds the 3 words.
3. Contention: core_req and dma_req held high from cycle 0 with STARVE_LIMIT=4 → starve_cnt reaches 4 at cycle 4; owner=1 at cycle 5; core_stall=1 while owner=1; core is serviced again after the burst.
4. Forced release: DMA holds dma_req=1 with dma_last=0 and MAX_BURST=8 → exactly 8 dma_gnt pulses, then owner=0 for at least 1 cycle with core_req=1 serviced.
5. DMA read of 0x20 (contents 0x12345678) → dma_rvalid pulses 1 cycle after dma_gnt; dma_rdata=0x12345678; dma_rvalid=0 on the next cycle.
6. Reset mid-burst: assert rst=0 after beat 2 of 5 → owner=0, dma_gnt=0, dma_rvalid=0 asynchronously; after release, core access is serviced immediately.
